// File: rtl/othello_pkg.sv
// Shared widths and field layout for solver result records.
package othello_pkg;

  localparam int unsigned WORD_W           = 24;
  localparam int unsigned WORDS_PER_RECORD = 6;
  localparam int unsigned RECORD_W         = 144;
  localparam int unsigned TASKID_W         = 16;
  localparam int unsigned BOARD_W          = 64;
  localparam int unsigned COUNT_W          = 32;
  localparam int unsigned IDX_W            = 3;

  localparam int unsigned TASKID_LSB = 0;
  localparam int unsigned RESULT_LSB = TASKID_LSB + TASKID_W;
  localparam int unsigned PAD_LSB    = RESULT_LSB + BOARD_W;
  localparam int unsigned PAD_W      = RECORD_W - PAD_LSB;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_RECORD - 1);

  // Word index within a record, wrapping after the last word.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/word_deserializer.sv
// Pulls 24-bit words from a 1-cycle-latency FIFO and assembles 144-bit records.
module word_deserializer
  import othello_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [WORD_W-1:0]   i_fifo_dout,
  input  logic                i_fifo_empty,
  input  logic                i_out_free,
  output logic                o_rd_en_c,
  output logic                o_done_c,
  output logic [RECORD_W-1:0] o_record_c
);

  logic [IDX_W-1:0]    r_req_idx;
  logic [IDX_W-1:0]    r_cap_idx;
  logic                r_rd_pend;
  logic [RECORD_W-1:0] r_asm;

  logic                w_rd_en;
  logic [RECORD_W-1:0] w_asm_next;

  // Only the final word of a record waits for the output register to free up.
  assign w_rd_en    = !reset && !i_fifo_empty && ((r_req_idx != LAST_IDX) || i_out_free);
  assign w_asm_next = {r_asm[RECORD_W-WORD_W-1:0], i_fifo_dout};

  assign o_rd_en_c  = w_rd_en;
  assign o_done_c   = r_rd_pend && (r_cap_idx == LAST_IDX);
  assign o_record_c = w_asm_next;

  // Clearing r_rd_pend on reset drops any word already in flight from the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_idx <= '0;
      r_cap_idx <= '0;
      r_rd_pend <= 1'b0;
      r_asm     <= '0;
    end else begin
      r_rd_pend <= w_rd_en;
      if (w_rd_en) begin
        r_req_idx <= idx_next(r_req_idx);
      end
      if (r_rd_pend) begin
        r_asm     <= w_asm_next;
        r_cap_idx <= idx_next(r_cap_idx);
      end
    end
  end

endmodule

// File: rtl/result_collector.sv
// Collects 6-word solver records from a FIFO and presents them on a valid/ready port.
module result_collector
  import othello_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [WORD_W-1:0]   fifo_dout,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [TASKID_W-1:0] res_taskid,
  output logic [BOARD_W-1:0]  res_result,
  output logic                pad_error,
  output logic [COUNT_W-1:0]  record_count
);

  logic                r_valid;
  logic [TASKID_W-1:0] r_taskid;
  logic [BOARD_W-1:0]  r_result;
  logic                r_pad_error;
  logic [COUNT_W-1:0]  r_count;

  logic                w_out_free;
  logic                w_handshake;
  logic                w_done;
  logic [RECORD_W-1:0] w_record;
  logic                w_pad_bad;

  assign w_out_free  = !r_valid || res_ready;
  assign w_handshake = r_valid && res_ready;
  assign w_pad_bad   = |w_record[PAD_LSB +: PAD_W];

  word_deserializer u_deser (
    .clock        (clock),
    .reset        (reset),
    .i_fifo_dout  (fifo_dout),
    .i_fifo_empty (fifo_empty),
    .i_out_free   (w_out_free),
    .o_rd_en_c    (fifo_rd_en),
    .o_done_c     (w_done),
    .o_record_c   (w_record)
  );

  // A completing record may load in the same cycle the held one is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_taskid    <= '0;
      r_result    <= '0;
      r_pad_error <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_done) begin
        r_valid  <= 1'b1;
        r_taskid <= w_record[TASKID_LSB +: TASKID_W];
        r_result <= w_record[RESULT_LSB +: BOARD_W];
        if (w_pad_bad) begin
          r_pad_error <= 1'b1;
        end
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
      if (w_handshake) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign res_valid    = r_valid;
  assign res_taskid   = r_taskid;
  assign res_result   = r_result;
  assign pad_error    = r_pad_error;
  assign record_count = r_count;

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameters: none; all widths SHALL come from the shared package constants in REQ-030.
REQ-002 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 fifo_dout  in  24  word from the solver output FIFO, valid the cycle after fifo_rd_en (standard-mode FIFO, 1-cycle read latency).
REQ-005 fifo_empty  in  1  solver output FIFO empty.
REQ-006 fifo_rd_en  out  1  pop one word from the solver output FIFO.
REQ-007 res_valid  out  1  result record available.
REQ-008 res_ready  in  1  downstream accepts record.
REQ-009 res_taskid  out  16  task id of held record.
REQ-010 res_result  out  64  solver result of held record.
REQ-011 pad_error  out  1  sticky: some record had non-zero pad bits.
REQ-012 record_count  out  32  number of records handed off.

Function
REQ-013 Record = 144 bits as 6 words of 24 bits, first word = bits [143:120], last word = bits [23:0].
REQ-014 Field map: [15:0] taskid, [79:16] result, [143:80] pad (SHALL be zero).
REQ-015 req_idx (0..5) = index of next word to request; fifo_rd_en = !reset && !fifo_empty && (req_idx < 5 || out_free).
REQ-016 out_free = !res_valid || res_ready (output register empty or being released this cycle).
REQ-017 Each fifo_rd_en cycle: req_idx increments, 5 wraps to 0; no read SHALL occur while fifo_empty.
REQ-018 Cycle after fifo_rd_en: fifo_dout SHALL be shifted into the 144-bit assembly register; cap_idx (0..5) increments, 5 wraps to 0.
REQ-019 On capture with cap_idx = 5: res_taskid/res_result SHALL load from the completed record and res_valid SHALL set; latency 6th fifo_rd_en cycle -> res_valid high = 2 cycles.
REQ-020 Collection of the next record's words 0..4 SHALL continue while res_valid is held; only the 6th request stalls on out_free.
REQ-021 res_valid, res_taskid, res_result SHALL hold stable while res_valid && !res_ready.
REQ-022 res_valid && res_ready: handshake; res_valid clears unless a new record loads the same cycle (then stays high with new data).
REQ-023 record_count SHALL increment by 1 per handshake, wrapping 2^32-1 -> 0.
REQ-024 Pad bits non-zero on record completion: pad_error SHALL set and stay set until reset; record still delivered.
REQ-025 Sustained throughput with res_ready=1 and FIFO non-empty: one record per 6 cycles.

Reset
REQ-026 During reset fifo_rd_en SHALL be 0.
REQ-027 Reset values: res_valid 0, res_taskid 0, res_result 0, pad_error 0, record_count 0, req_idx 0, cap_idx 0, assembly register 0.
REQ-028 Reset mid-record SHALL discard partial words; a word whose read was issued the cycle before reset SHALL be dropped, not captured.
REQ-029 This block SHALL NOT reset the FIFO; FIFO/collector word alignment after mid-record reset is the system's responsibility.

Structure
REQ-030 Shared package othello_pkg SHALL hold WORD_W=24, WORDS_PER_RECORD=6, RECORD_W=144, TASKID_W=16, BOARD_W=64, and the field bit offsets.
REQ-031 Sub-module word_deserializer (rd_en issue, capture, idx counters, assembly register) SHALL be instantiated once; output register, pad check and counter stay in result_collector.

Verification
REQ-032 One record taskid 16'h00A5, result 64'h0123_4567_89AB_CDEF, pad 0, res_ready=1 -> res_valid one cycle with those values, record_count=1, pad_error=0.
REQ-033 Three back-to-back records, FIFO never empty, res_ready=1 -> fifo_rd_en high 18 consecutive cycles, res_valid pulses every 6 cycles, record_count=3.
REQ-034 res_ready=0 for 20 cycles with 2 records queued -> record 1 held stable, exactly 5 further reads then fifo_rd_en low; on res_ready=1 record 1 handshakes, record 2 valid 2 cycles later.
REQ-035 Record with pad bit 100 set -> record delivered, pad_error=1 and stays 1 through later clean records until reset.
REQ-036 Reset asserted after 3 words of a record -> all outputs zero, fifo_rd_en 0 during reset; after realigned 6-word record, correct fields delivered.
REQ-037 fifo_empty toggling every other cycle mid-record -> no rd_en while empty, record assembled correctly in 12 cycles.
